// File: rtl/pdp8_kw_prog.sv
// Programmable real-time clock on the PDP-8 IOT bus: a prescaled up-counter with
// preset reload, one-shot and free-run overflow modes, an overflow flag and an interrupt.
module pdp8_kw_prog #(
  parameter logic [5:0] DEVICE_CODE = 6'o13,
  parameter int         PRESCALE    = 4,
  parameter int         CNT_WIDTH   = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        iot,
  input  logic [3:0]  state,
  input  logic [11:0] mb,
  input  logic [5:0]  io_select,
  input  logic [11:0] io_data_in,
  output logic [11:0] io_data_out,
  output logic        io_data_avail,
  output logic        io_clear_ac,
  output logic        io_selected,
  output logic        io_interrupt,
  output logic        io_skip
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONES = '1;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] preset_q, preset_d;
  logic [PW-1:0]        pre_q, pre_d;
  logic [1:0]           mode_q, mode_d;
  logic                 clk_en_q, clk_en_d;
  logic                 int_en_q, int_en_d;
  logic                 flag_q, flag_d;

  logic       selected;
  logic       tick;
  logic       load;
  logic       overflow;
  logic [2:0] fn;
  logic       unused_ok;

  assign fn        = mb[2:0];
  assign selected  = (state == 4'd1) && iot && (io_select == DEVICE_CODE);
  assign load      = selected && (fn == 3'd4);
  assign tick      = clk_en_q && (pre_q == PRE_MAX);
  // A load on a tick edge suppresses both the increment and the overflow.
  assign overflow  = tick && !load && (cnt_q == CNT_ONES);
  assign unused_ok = ^{mb[11:3], io_data_in};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      preset_q <= '0;
      pre_q    <= '0;
      mode_q   <= 2'd0;
      clk_en_q <= 1'b0;
      int_en_q <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      preset_q <= preset_d;
      pre_q    <= pre_d;
      mode_q   <= mode_d;
      clk_en_q <= clk_en_d;
      int_en_q <= int_en_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    preset_d = preset_q;
    mode_d   = mode_q;
    clk_en_d = clk_en_q;
    int_en_d = int_en_q;
    flag_d   = flag_q;

    if (tick && !load) begin
      if (overflow) begin
        flag_d = 1'b1;
        cnt_d  = (mode_q == 2'd1) ? preset_q : '0;
        if (mode_q == 2'd2) clk_en_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end

    // IOT effects come after the tick so an IOT enable beats the one-shot stop,
    // while a flag clear never beats a simultaneous overflow.
    if (selected) begin
      case (fn)
        3'd1, 3'd7: begin
          clk_en_d = 1'b1;
          int_en_d = 1'b1;
        end
        3'd2: begin
          clk_en_d = 1'b0;
          int_en_d = 1'b0;
          if (!overflow) flag_d = 1'b0;
        end
        3'd3: begin
          if (!overflow) flag_d = 1'b0;
        end
        3'd4: begin
          preset_d = io_data_in[CNT_WIDTH-1:0];
          cnt_d    = io_data_in[CNT_WIDTH-1:0];
        end
        3'd6: begin
          mode_d   = io_data_in[1:0];
          int_en_d = io_data_in[2];
          clk_en_d = io_data_in[3];
        end
        default: ;
      endcase
    end

    // Prescaler restarts from 0 whenever counting is (re)enabled, stopped or reloaded.
    if (!clk_en_q || !clk_en_d || load || tick) pre_d = '0;
    else                                        pre_d = pre_q + PW'(1);
  end

  always_comb begin
    io_selected   = selected;
    io_skip       = 1'b0;
    io_data_out   = 12'd0;
    io_data_avail = 1'b0;
    io_clear_ac   = 1'b0;
    if (selected) begin
      io_skip = (fn == 3'd3) && flag_q;
      if (fn == 3'd5) begin
        io_data_out   = 12'(cnt_q);
        io_data_avail = 1'b1;
        io_clear_ac   = 1'b1;
      end
    end
  end

  assign io_interrupt = int_en_q && flag_q;

endmodule

// File: doc/pdp8_kw_prog.md
Name: pdp8_kw_prog

Overview:
- Programmable real-time clock for the PDP-8 IOT bus; successor to the fixed-rate KW8/I clock.
- Counts prescaled ticks of the system clock in a CNT_WIDTH up-counter.
- Raises a flag, and optionally an interrupt, on counter overflow.
- Three overflow modes: free-run, preset-reload, one-shot. Counter and preset are software loadable and readable through AC.

Parameters:
- DEVICE_CODE, 6'o13: IOT device select code.
- PRESCALE, 4: clk cycles per counter tick; legal range 1..256.
- CNT_WIDTH, 12: counter/preset width; legal range 2..12.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- iot  input  1  current instruction is an IOT
- state  input  4  CPU major state (F0=0, F1=1, F2=2, F3=3)
- mb  input  12  memory buffer; mb[2:0] is the IOT function
- io_select  input  6  IOT device code (mb[8:3])
- io_data_in  input  12  AC value presented during F1
- io_data_out  output  12  data to AC
- io_data_avail  output  1  io_data_out valid this cycle
- io_clear_ac  output  1  CPU clears AC before OR-ing io_data_out
- io_selected  output  1  device addressed
- io_interrupt  output  1  interrupt request
- io_skip  output  1  skip request

Behaviour:
- One clock, asynchronous active-low reset. reset_n low clears counter, preset, prescaler, mode, clk_en, int_en and flag to 0.
- Reset mid-operation aborts the count immediately. No tick or flag is produced until software re-enables counting.
- "Selected" means state==F1 && iot && io_select==DEVICE_CODE. F1 lasts one clk per instruction.
- Combinational outputs (all 0 unless selected):
  - io_selected=1 when selected.
  - io_skip=1 for fn 3 when flag=1.
  - io_data_out/io_data_avail/io_clear_ac only for fn 5: io_data_out = counter zero-extended to 12 bits, io_data_avail=1, io_clear_ac=1.
  - Otherwise io_data_out=0.
- io_interrupt = int_en && flag. Level output, held until the flag is cleared.
- IOT functions (mb[2:0]) take effect on the clk edge ending the selected F1 cycle:
  - 0: no-op. Selected, no effect.
  - 1 CLEN: clk_en=1, int_en=1.
  - 2 CCFF: flag=0, clk_en=0, int_en=0.
  - 3 CLSK: skip if flag; flag=0.
  - 4 CLLD: preset = io_data_in[CNT_WIDTH-1:0], counter = same value, prescaler = 0.
  - 5 CLRD: counter to AC; no state change.
  - 6 CLMD: mode = io_data_in[1:0], int_en = io_data_in[2], clk_en = io_data_in[3].
  - 7 CECI: clk_en=1, int_en=1.
- Prescaler:
  - While clk_en=1, counts 0..PRESCALE-1 and wraps.
  - tick = clk_en && prescaler==PRESCALE-1. PRESCALE=1 gives a tick every clk.
  - While clk_en=0, prescaler is held at 0, so the first tick comes exactly PRESCALE clks after enable.
- Counter on tick:
  - Not all-ones: counter+1.
  - All-ones: overflow; flag=1, and the counter then follows the mode:
    - Mode 0 free-run: counter wraps to 0.
    - Mode 1 reload: counter = preset.
    - Mode 2 one-shot: counter wraps to 0 and clk_en=0.
    - Mode 3 is reserved and behaves as mode 0.
- Simultaneous events:
  - Overflow tick and fn 3 or fn 2 in the same cycle: flag ends 1. Set wins.
  - For fn 2 with tick: clk_en ends 0, but that tick's count/overflow still applies.
  - Tick and fn 4: load wins; no increment, no overflow.
  - Tick and fn 6: the new mode/enables apply from the next cycle; the current tick uses the old mode.
  - One-shot overflow and fn 1/7 in the same cycle: clk_en ends 1. IOT wins.
- The flag sets on the tick edge regardless of CPU state. No F3 qualification.
- Widths: all arithmetic is modulo 2^CNT_WIDTH. AC bits above CNT_WIDTH are ignored on load and read back as 0.

Test Plan:
1. Defaults (PRESCALE=4, CNT_WIDTH=12): reset_n low then high; fn 4 with AC=7775; fn 6 with AC=0011 (mode 1, clk_en=1, int_en=0) -> after 12 clks flag=1, counter=7775, io_interrupt=0; fn 3 -> io_skip=1 in F1, flag=0 next cycle.
2. Free-run: load 7776, fn 6 AC=0014 (mode 0, int_en, clk_en) -> overflow after 8 clks, counter=0000, io_interrupt=1; 4 clks later counter=0001; io_interrupt stays 1 until fn 3.
3. One-shot: load 7777, fn 6 AC=0012 -> flag=1 after 4 clks, counter=0000, clk_en=0; counter still 0000 after a further 40 clks; fn 5 -> io_data_out=0000, io_data_avail=1, io_clear_ac=1.
4. Collision: arrange the overflow tick on the same edge as the CLSK F1 -> io_skip reflects the old flag, flag ends 1. Arrange fn 4 AC=0100 on a tick edge -> counter=0100, no increment.
5. Asynchronous reset: assert reset_n low between clk edges mid-count with flag=1 -> counter, flag, io_interrupt are 0 immediately, without waiting for a clk edge; no tick for 20 clks after release.
6. Parameter sweep: CNT_WIDTH=4, PRESCALE=1, DEVICE_CODE=6'o40 -> fn 4 AC=7777 loads 17; overflow on the next tick; fn 5 reads 0000; an IOT with io_select=13 gives io_selected=0.
